// File: rtl/decode_pkg.sv
// Shared types and constants for the decode stage: immediate modes, default
// field geometry, the decoded bundle layout and a field-extension helper.
package decode_pkg;

    localparam int DEF_XLEN   = 16;
    localparam int DEF_REG_AW = 4;
    localparam int DEF_OPW    = 4;
    localparam int DEF_ILEN   = DEF_OPW + 3 * DEF_REG_AW;
    localparam int DEF_NREGS  = 2 ** DEF_REG_AW;

    // Instruction layout, MSB to LSB: opcode, rd, rs1, rs2.
    localparam int RS2_LSB = 0;
    localparam int RS1_LSB = DEF_REG_AW;
    localparam int RD_LSB  = 2 * DEF_REG_AW;
    localparam int OP_LSB  = 3 * DEF_REG_AW;

    typedef enum logic [1:0] {
        IMM_S4 = 2'd0,
        IMM_S8 = 2'd1,
        IMM_Z8 = 2'd2,
        IMM_BR = 2'd3
    } imm_mode_e;

    typedef struct packed {
        logic [DEF_XLEN-1:0]   pc;
        logic [DEF_XLEN-1:0]   a;
        logic [DEF_XLEN-1:0]   b;
        logic [DEF_XLEN-1:0]   imm;
        logic [DEF_REG_AW-1:0] rd;
        logic [DEF_REG_AW-1:0] rs1;
        logic [DEF_REG_AW-1:0] rs2;
    } decode_bundle_t;

    // Keep the low w bits of v; fill the rest with v[w-1] when sign is set.
    function automatic logic [63:0] ext_field(input logic [63:0] v, input int w, input logic sign);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            r[i] = (i < w) ? v[i] : (sign & v[w-1]);
        end
        return r;
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// Register file: 2 combinational read ports, 1 write port, r0 hardwired to
// zero, synchronous reset, write-first bypass on the read ports.
module decode_regfile #(
    parameter int XLEN   = 16,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [REG_AW-1:0] raddr1_i,
    input  logic [REG_AW-1:0] raddr2_i,
    output logic [XLEN-1:0]   rdata1_o,
    output logic [XLEN-1:0]   rdata2_o
);

    localparam int NREGS = 2 ** REG_AW;

    logic [XLEN-1:0] regs_q [NREGS];

    // NOTE: the reset clears every entry because software relies on the
    // architectural zero state; this keeps the array in flops, not SRAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                // NOTE: state is updated with non-blocking assignments so all
                // flops sample the same pre-edge values.
                regs_q[i] <= '0;
            end
        end else if (we_i && waddr_i != '0) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == '0)                   ? '0      :
                      (we_i && waddr_i == raddr1_i)      ? wdata_i :
                                                           regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0)                   ? '0      :
                      (we_i && waddr_i == raddr2_i)      ? wdata_i :
                                                           regs_q[raddr2_i];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field split, register read with bypass, immediate generation
// and one valid/ready output slot. Define DECODE_HAZARD_DETECT_EN to stall on load-use.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int ILEN   = DEF_ILEN,
    parameter int REG_AW = DEF_REG_AW,
    parameter int OPW    = DEF_OPW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ILEN-1:0]   ir,
    input  logic [XLEN-1:0]   pc,
    input  logic [1:0]        immgenop,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [XLEN-1:0]   wr_data,
    input  logic              flush,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   pc_out,
    output logic [XLEN-1:0]   a,
    output logic [XLEN-1:0]   b,
    output logic [XLEN-1:0]   imm,
    output logic [REG_AW-1:0] rd_out,
    output logic [REG_AW-1:0] rs1_out,
    output logic [REG_AW-1:0] rs2_out,
    output logic              stall_hazard
);

    localparam int RS1_LO = REG_AW;
    localparam int RD_LO  = 2 * REG_AW;

    logic [REG_AW-1:0] rd_f, rs1_f, rs2_f;
    logic [XLEN-1:0]   rdata1, rdata2, imm_gen;
    logic              capture;

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   pc_q, pc_d, a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [REG_AW-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;

    assign rs2_f = ir[0 +: REG_AW];
    assign rs1_f = ir[RS1_LO +: REG_AW];
    assign rd_f  = ir[RD_LO +: REG_AW];

    decode_regfile #(.XLEN(XLEN), .REG_AW(REG_AW)) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we_i     (wr_en),
        .waddr_i  (wr_addr),
        .wdata_i  (wr_data),
        .raddr1_i (rs1_f),
        .raddr2_i (rs2_f),
        .rdata1_o (rdata1),
        .rdata2_o (rdata2)
    );

`ifdef DECODE_HAZARD_DETECT_EN
    assign stall_hazard = in_valid && ex_is_load && ex_rd != '0 &&
                          (ex_rd == rs1_f || ex_rd == rs2_f);
    logic unused_bits;
    assign unused_bits = ^ir[ILEN-1:3*REG_AW];
`else
    assign stall_hazard = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{ir[ILEN-1:3*REG_AW], ex_is_load, ex_rd};
`endif

    assign in_ready = (!valid_q || out_ready) && !stall_hazard && !flush;
    assign capture  = in_valid && in_ready;

    always_comb begin
        imm_gen = '0;
        unique case (imm_mode_e'(immgenop))
            IMM_S4: imm_gen = XLEN'(ext_field(64'(ir), REG_AW, 1'b1));
            IMM_S8: imm_gen = XLEN'(ext_field(64'(ir), 2 * REG_AW, 1'b1));
            IMM_Z8: imm_gen = XLEN'(ext_field(64'(ir), 2 * REG_AW, 1'b0));
            IMM_BR: imm_gen = XLEN'(ext_field(64'(ir), 3 * REG_AW, 1'b1) << 1);
        endcase
    end

    // NOTE: every _d starts as its _q so no path through this block leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        a_d     = a_q;
        b_d     = b_q;
        imm_d   = imm_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d = 1'b1;
            pc_d    = pc;
            a_d     = rdata1;
            b_d     = rdata2;
            imm_d   = imm_gen;
            rd_d    = rd_f;
            rs1_d   = rs1_f;
            rs2_d   = rs2_f;
        end else if (out_ready || !valid_q) begin
            // Slot drains with nothing new: either idle or a hazard bubble.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
        end
    end

    assign out_valid = valid_q;
    assign pc_out    = pc_q;
    assign a         = a_q;
    assign b         = b_q;
    assign imm       = imm_q;
    assign rd_out    = rd_q;
    assign rs1_out   = rs1_q;
    assign rs2_out   = rs2_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed sequences, an immediate
// vector table and randomized traffic against a behavioural model.
module tb_decode_stage;
    import decode_pkg::*;

`ifdef DECODE_HAZARD_DETECT_EN
    localparam bit HAZ = 1'b1;
`else
    localparam bit HAZ = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] ir;
    logic [15:0] pc;
    logic [1:0]  immgenop;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        flush;
    logic        ex_is_load;
    logic [3:0]  ex_rd;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] pc_out, a, b, imm;
    logic [3:0]  rd_out, rs1_out, rs2_out;
    logic        stall_hazard;

    decode_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ir           (ir),
        .pc           (pc),
        .immgenop     (immgenop),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .flush        (flush),
        .ex_is_load   (ex_is_load),
        .ex_rd        (ex_rd),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .pc_out       (pc_out),
        .a            (a),
        .b            (b),
        .imm          (imm),
        .rd_out       (rd_out),
        .rs1_out      (rs1_out),
        .rs2_out      (rs2_out),
        .stall_hazard (stall_hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: architectural registers plus the expected output slot.
    int             m_regs [16];
    bit             m_valid;
    decode_bundle_t m_slot;

    typedef struct {
        logic [15:0] ir;
        logic [1:0]  mode;
        logic [15:0] exp_imm;
    } imm_vec_t;

    imm_vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sext(input int v, input int bits);
        int m;
        m = v & ((1 << bits) - 1);
        if (m >= (1 << (bits - 1))) m = m - (1 << bits);
        return m;
    endfunction

    function automatic int exp_imm(input int ir_v, input int mode);
        int r;
        case (mode)
            0:       r = sext(ir_v, 4);
            1:       r = sext(ir_v, 8);
            2:       r = ir_v & 255;
            default: r = sext(ir_v, 12) * 2;
        endcase
        return r & 16'hFFFF;
    endfunction

    function automatic int read_reg(input int r);
        if (r == 0) return 0;
        if (wr_en && int'(wr_addr) == r) return int'(wr_data);
        return m_regs[r];
    endfunction

    // One clock: check combinational outputs, advance the model at the edge,
    // then check the registered outputs.
    task automatic cycle();
        int rs1, rs2, rd;
        bit hz, rdy, cap;
        #1;
        rs2 = int'(ir) % 16;
        rs1 = (int'(ir) / 16) % 16;
        rd  = (int'(ir) / 256) % 16;
        hz  = HAZ && in_valid && ex_is_load && ex_rd != 0 &&
              (int'(ex_rd) == rs1 || int'(ex_rd) == rs2);
        rdy = (!m_valid || out_ready) && !hz && !flush;
        if (!rst) begin
            check("in_ready", 32'(in_ready), 32'(rdy));
            check("stall_hazard", 32'(stall_hazard), 32'(hz));
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 0;
            m_valid = 1'b0;
            m_slot  = '0;
        end else begin
            cap = in_valid && rdy;
            if (cap) begin
                m_slot.pc  = pc;
                m_slot.a   = 16'(read_reg(rs1));
                m_slot.b   = 16'(read_reg(rs2));
                m_slot.imm = 16'(exp_imm(int'(ir), int'(immgenop)));
                m_slot.rd  = 4'(rd);
                m_slot.rs1 = 4'(rs1);
                m_slot.rs2 = 4'(rs2);
            end
            if (flush)                      m_valid = 1'b0;
            else if (cap)                   m_valid = 1'b1;
            else if (out_ready || !m_valid) m_valid = 1'b0;
            if (wr_en && wr_addr != 0) m_regs[wr_addr] = int'(wr_data);
        end
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("pc_out", 32'(pc_out), 32'(m_slot.pc));
        check("a", 32'(a), 32'(m_slot.a));
        check("b", 32'(b), 32'(m_slot.b));
        check("imm", 32'(imm), 32'(m_slot.imm));
        check("rd_out", 32'(rd_out), 32'(m_slot.rd));
        check("rs1_out", 32'(rs1_out), 32'(m_slot.rs1));
        check("rs2_out", 32'(rs2_out), 32'(m_slot.rs2));
    endtask

    task automatic set_idle();
        rst        = 1'b0;
        in_valid   = 1'b0;
        ir         = '0;
        pc         = '0;
        immgenop   = '0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        flush      = 1'b0;
        ex_is_load = 1'b0;
        ex_rd      = '0;
        out_ready  = 1'b1;
    endtask

    initial begin
        vecs[0] = '{16'h10F8, 2'd1, 16'hFFF8};
        vecs[1] = '{16'h10F8, 2'd2, 16'h00F8};
        vecs[2] = '{16'h10F8, 2'd3, 16'h01F0};
        vecs[3] = '{16'h0008, 2'd0, 16'hFFF8};
        vecs[4] = '{16'h0007, 2'd0, 16'h0007};
        vecs[5] = '{16'h0800, 2'd3, 16'hF000};
        vecs[6] = '{16'h07FF, 2'd3, 16'h0FFE};
        vecs[7] = '{16'hF0FF, 2'd2, 16'h00FF};
        vecs[8] = '{16'h0080, 2'd1, 16'hFF80};
        vecs[9] = '{16'hFFFF, 2'd0, 16'hFFFF};

        m_valid = 1'b0;
        m_slot  = '0;
        for (int i = 0; i < 16; i++) m_regs[i] = 0;

        // Reset, dirty the register file, then reset for two cycles.
        set_idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        wr_en = 1'b1;
        for (int i = 1; i < 16; i++) begin
            wr_addr = 4'(i);
            wr_data = 16'(i * 16'h1111);
            cycle();
        end
        set_idle();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_pc_out", 32'(pc_out), 32'd0);
        check("rst_a", 32'(a), 32'd0);
        check("rst_b", 32'(b), 32'd0);
        check("rst_imm", 32'(imm), 32'd0);
        check("rst_fields", {20'd0, rd_out, rs1_out, rs2_out}, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Every register reads zero after reset.
        in_valid = 1'b1;
        for (int r = 0; r < 16; r += 2) begin
            ir = {4'h0, 4'h1, 4'(r), 4'(r + 1)};
            cycle();
            check("rst_reg_a", 32'(a), 32'd0);
            check("rst_reg_b", 32'(b), 32'd0);
        end

        // Write r3, then capture an instruction reading it.
        set_idle();
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234;
        cycle();
        set_idle();
        in_valid = 1'b1; ir = 16'h1530; pc = 16'h0040;
        cycle();
        check("wr_rd_valid", 32'(out_valid), 32'd1);
        check("wr_rd_a", 32'(a), 32'h1234);
        check("wr_rd_b", 32'(b), 32'd0);
        check("wr_rd_rd", 32'(rd_out), 32'd5);
        check("wr_rd_pc", 32'(pc_out), 32'h0040);

        // Same-cycle write-first bypass, then a plain read of the stored value.
        ir = 16'h1270; pc = 16'h0042;
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'hBEEF;
        cycle();
        check("bypass_a", 32'(a), 32'hBEEF);
        wr_en = 1'b0; ir = 16'h1307; pc = 16'h0044;
        cycle();
        check("stored_b", 32'(b), 32'hBEEF);

        // Writes to r0 are dropped, also with a same-cycle read.
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF; ir = 16'h1400;
        cycle();
        check("r0_bypass_a", 32'(a), 32'd0);
        wr_en = 1'b0; pc = 16'h0046;
        cycle();
        check("r0_read_a", 32'(a), 32'd0);
        check("r0_read_b", 32'(b), 32'd0);

        // Backpressure holds the slot; flush then empties it without capture.
        ir = 16'h1123; pc = 16'h0080;
        cycle();
        out_ready = 1'b0; ir = 16'h1456; pc = 16'h0090;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_pc", 32'(pc_out), 32'h0080);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        flush = 1'b1;
        cycle();
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_pc", 32'(pc_out), 32'h0080);
        set_idle();
        cycle();

        // Immediate modes from the vector table.
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ir = vecs[i].ir; immgenop = vecs[i].mode; pc = 16'(i);
            cycle();
            check("imm_vec", 32'(imm), 32'(vecs[i].exp_imm));
        end

        // Load-use hazard on rs1.
        set_idle();
        in_valid = 1'b1; ir = 16'h1120; pc = 16'h00A0;
        cycle();
        ex_is_load = 1'b1; ex_rd = 4'd4; ir = 16'h1246; pc = 16'h00A2;
        cycle();
        if (HAZ) begin
            check("haz_bubble", 32'(out_valid), 32'd0);
            check("haz_stall", 32'(stall_hazard), 32'd1);
            check("haz_in_ready", 32'(in_ready), 32'd0);
            cycle();
            check("haz_persist", 32'(in_ready), 32'd0);
            ex_is_load = 1'b0;
            cycle();
        end else begin
            check("nohaz_stall", 32'(stall_hazard), 32'd0);
        end
        check("haz_capture_valid", 32'(out_valid), 32'd1);
        check("haz_capture_rs1", 32'(rs1_out), 32'd4);
        check("haz_capture_pc", 32'(pc_out), 32'h00A2);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            rst        = ($urandom_range(0, 59) == 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            ir         = 16'($urandom);
            pc         = 16'($urandom);
            immgenop   = 2'($urandom);
            out_ready  = ($urandom_range(0, 9) < 7);
            flush      = ($urandom_range(0, 9) == 0);
            wr_en      = ($urandom_range(0, 1) == 1);
            wr_addr    = ($urandom_range(0, 3) == 0) ? ir[7:4] : 4'($urandom);
            wr_data    = 16'($urandom);
            ex_is_load = ($urandom_range(0, 2) == 0);
            ex_rd      = ($urandom_range(0, 1) == 1) ? ir[3:0] : 4'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
